// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
//
// Definitions shared by the MIPS-subset control units (single-cycle and
// multi-cycle): opcode values, datapath mux encodings, the multi-cycle state
// encoding, and a bundle type for the Moore-decoded control word.
//
// decodeState() gives the control word that belongs to each multi-cycle state.
// It returns only the part that depends on the state alone. The bits that
// also depend on the memory handshake (IRWrite and PCWrite in FETCH, and the
// retire pulse on a store) are added by the FSM itself.
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALUOp encodings seen by the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_SUB   = 2'd3;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Multi-cycle controller states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_LW_WB     = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12
    } state_t;

    // Moore part of the control word
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
    } ctrl_t;

    // State-only control word; anything not set stays 0
    function automatic ctrl_t decodeState(input state_t state);
        ctrl_t c;
        c = '0;
        case (state)
            ST_FETCH: begin
                c.memRead  = 1'b1;
                c.iorD     = 1'b0;
                c.aluSrcA  = 1'b0;
                c.aluSrcB  = SRCB_FOUR;
                c.aluOp    = ALUOP_ADD;
                c.pcSource = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Branch target is precomputed here in case the opcode is beq
                c.aluSrcA = 1'b0;
                c.aluSrcB = SRCB_IMM_SH2;
                c.aluOp   = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            ST_LW_WB: begin
                c.regWrite  = 1'b1;
                c.memtoReg  = 1'b1;
                c.regDst    = 1'b0;
                c.instrDone = 1'b1;
            end
            ST_MEM_WR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            ST_R_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_RT;
                c.aluOp   = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                c.regWrite  = 1'b1;
                c.regDst    = 1'b1;
                c.memtoReg  = 1'b0;
                c.instrDone = 1'b1;
            end
            ST_ADDI_WB: begin
                c.regWrite  = 1'b1;
                c.regDst    = 1'b0;
                c.instrDone = 1'b1;
            end
            ST_BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_RT;
                c.aluOp       = ALUOP_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSource    = PCSRC_ALUOUT;
                c.instrDone   = 1'b1;
            end
            ST_JUMP: begin
                c.pcWrite   = 1'b1;
                c.pcSource  = PCSRC_JUMP;
                c.instrDone = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_mem_stall_timer.sv
// ----------------------------------------------------------------------------
// mem_stall_timer
//
// Counts consecutive cycles that the controller spends stalled on the memory
// handshake and raises a sticky error flag once the count reaches MEM_TIMEOUT.
// The flag is only an indication: the FSM keeps waiting for mem_ready.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset (clears count and flag)
//   i_waiting      controller is in a state that waits on memory
//   i_memReady     memory completes the current access this cycle
//   i_stateChange  controller moves to a different state at the next edge
//   o_memErr       sticky timeout flag
// ----------------------------------------------------------------------------
module mem_stall_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_waiting,
    input  logic i_memReady,
    input  logic i_stateChange,
    output logic o_memErr
);

    localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

    logic [3:0] r_stallCount;
    logic       r_memErr;
    logic [3:0] w_countInc;
    logic       w_stalled;

    assign w_countInc = r_stallCount + 4'd1;
    assign w_stalled  = i_waiting && !i_memReady;

    // Stall counter and sticky error flag. Any state change restarts the
    // count so only a single uninterrupted wait can trip the timeout; the
    // count stops at TIMEOUT so it never wraps back to a harmless value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stallCount <= 4'd0;
            r_memErr     <= 1'b0;
        end else if (i_stateChange) begin
            r_stallCount <= 4'd0;
        end else if (w_stalled && (r_stallCount != TIMEOUT)) begin
            r_stallCount <= w_countInc;
            if (w_countInc == TIMEOUT) begin
                r_memErr <= 1'b1;
            end
        end
    end

    assign o_memErr = r_memErr;

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multi-cycle MIPS-subset datapath (shared memory, one
// ALU). It steps each instruction through fetch, decode, execute, memory and
// writeback, and it waits on the memory ready handshake.
//
// Ports:
//   i_clk, i_rst_n     clock and synchronous active-low reset
//   i_opcode           IR[31:26], valid from DECODE onward
//   i_mem_ready        memory completes the current access this cycle
//   i_zero             ALU zero flag (used by the datapath's PC-write gate)
//   o_PCWrite ..       datapath enables and mux selects
//   o_instr_done       one-cycle pulse when an instruction retires
//   o_illegal_op       one-cycle pulse in DECODE for an unsupported opcode
//   o_mem_err          sticky memory-timeout flag
//
// The control word is registered. It is loaded from the decode of the next
// state, so it always matches the current state and has no combinational
// path from i_opcode. Only three bits also depend on i_mem_ready in the
// current cycle: IRWrite/PCWrite in FETCH and instr_done on the cycle that
// completes a store. illegal_op comes from the DECODE next-state decision.
// ----------------------------------------------------------------------------
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_zero,
    output logic       o_PCWrite,
    output logic       o_PCWriteCond,
    output logic       o_IorD,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_MemtoReg,
    output logic       o_RegDst,
    output logic       o_RegWrite,
    output logic       o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic [1:0] o_PCSource,
    output logic       o_instr_done,
    output logic       o_illegal_op,
    output logic       o_mem_err
);

    state_t r_state;
    ctrl_t  r_ctrl;
    logic   r_inFetch;
    logic   r_inMemWr;

    state_t w_nextState;
    logic   w_illegal;
    logic   w_waiting;
    logic   w_stateChange;
    logic   w_unusedZero;

    // The branch decision (PCWriteCond & zero) is made in the datapath, so
    // the controller only passes zero through the unused-signal sink.
    assign w_unusedZero = i_zero;

    // Next-state selection. Wait states hold until the memory reports
    // completion. An unsupported opcode in DECODE goes back to FETCH and
    // raises illegal_op for that one cycle.
    always_comb begin
        w_nextState = r_state;
        w_illegal   = 1'b0;
        case (r_state)
            ST_IDLE:      w_nextState = ST_FETCH;
            ST_FETCH:     if (i_mem_ready) w_nextState = ST_DECODE;
            ST_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:     w_nextState = ST_R_EXEC;
                    OP_LW, OP_SW: w_nextState = ST_MEM_ADDR;
                    OP_ADDI:      w_nextState = ST_ADDI_EXEC;
                    OP_BEQ:       w_nextState = ST_BRANCH;
                    OP_J:         w_nextState = ST_JUMP;
                    default: begin
                        w_nextState = ST_FETCH;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR:  w_nextState = (i_opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:    if (i_mem_ready) w_nextState = ST_LW_WB;
            ST_LW_WB:     w_nextState = ST_FETCH;
            ST_MEM_WR:    if (i_mem_ready) w_nextState = ST_FETCH;
            ST_R_EXEC:    w_nextState = ST_R_WB;
            ST_R_WB:      w_nextState = ST_FETCH;
            ST_ADDI_EXEC: w_nextState = ST_ADDI_WB;
            ST_ADDI_WB:   w_nextState = ST_FETCH;
            ST_BRANCH:    w_nextState = ST_FETCH;
            ST_JUMP:      w_nextState = ST_FETCH;
            default:      w_nextState = ST_IDLE;
        endcase
    end

    // State register plus the registered control word. Reset drops straight
    // to IDLE with an all-zero word, so an interrupted instruction leaves no
    // partial write behind.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ctrl    <= '0;
            r_inFetch <= 1'b0;
            r_inMemWr <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ctrl    <= decodeState(w_nextState);
            r_inFetch <= (w_nextState == ST_FETCH);
            r_inMemWr <= (w_nextState == ST_MEM_WR);
        end
    end

    assign w_waiting     = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                           (r_state == ST_MEM_WR);
    assign w_stateChange = (w_nextState != r_state);

    mem_stall_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_stallTimer (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_waiting     (w_waiting),
        .i_memReady    (i_mem_ready),
        .i_stateChange (w_stateChange),
        .o_memErr      (o_mem_err)
    );

    // The instruction register and the PC+4 update only commit once the
    // fetch read has actually returned data.
    assign o_IRWrite     = r_inFetch && i_mem_ready;
    assign o_PCWrite     = r_ctrl.pcWrite || (r_inFetch && i_mem_ready);
    assign o_instr_done  = r_ctrl.instrDone || (r_inMemWr && i_mem_ready);
    assign o_illegal_op  = w_illegal;

    assign o_PCWriteCond = r_ctrl.pcWriteCond;
    assign o_IorD        = r_ctrl.iorD;
    assign o_MemRead     = r_ctrl.memRead;
    assign o_MemWrite    = r_ctrl.memWrite;
    assign o_MemtoReg    = r_ctrl.memtoReg;
    assign o_RegDst      = r_ctrl.regDst;
    assign o_RegWrite    = r_ctrl.regWrite;
    assign o_ALUSrcA     = r_ctrl.aluSrcA;
    assign o_ALUSrcB     = r_ctrl.aluSrcB;
    assign o_ALUOp       = r_ctrl.aluOp;
    assign o_PCSource    = r_ctrl.pcSource;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS-subset processor simulator. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps.
- Supports opcodes R-format(0), lw(35), sw(43), beq(4), j(2) and addi(8), using the existing ALUOp encoding.
- Stalls on a memory ready handshake.
- Sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
- MEM_TIMEOUT, 15, max stall cycles waiting on mem_ready before flagging mem_err (4-bit counter).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- zero  input  1  ALU zero flag
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if zero
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data select: 1=MDR
- RegDst  output  1  1=rd, 0=rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=rs
- ALUSrcB  output  2  0=rt, 1=const 4, 2=signext imm, 3=signext imm<<2
- ALUOp  output  2  0=add, 2=funct, 3=sub/compare
- PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_err  output  1  sticky memory-timeout flag, cleared only by reset

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- rst_n=0 at a clock edge forces:
  - state=IDLE
  - stall counter=0
  - mem_err=0
- In IDLE all outputs are 0. IDLE always moves to FETCH on the next clock. This includes reset asserted mid-instruction: any state returns to IDLE with no partial writes.
- Outputs are Moore-decoded from the state. Exception: IRWrite, PCWrite in FETCH, and MemRead/MemWrite completion are qualified by mem_ready (see FETCH, MEM_RD and MEM_WR).
- Unlisted outputs are 0 in every state.
- States and actions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite=PCWrite=mem_ready. Hold while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (precompute branch target). Next state by opcode:
    - 0 -> R_EXEC
    - 35 or 43 -> MEM_ADDR
    - 8 -> ADDI_EXEC
    - 4 -> BRANCH
    - 2 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for that cycle.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Go to MEM_RD if opcode=35, else MEM_WR.
  - MEM_RD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to LW_WB.
  - LW_WB: RegWrite=1, MemtoReg=1, RegDst=0. instr_done=1. Go to FETCH.
  - MEM_WR: MemWrite=1, IorD=1. Hold until mem_ready=1, then go to FETCH with instr_done=1 in the completing cycle.
  - R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Go to R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0. instr_done=1. Go to FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Go to ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0. instr_done=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=3, PCWriteCond=1, PCSource=1. instr_done=1. Go to FETCH.
  - JUMP: PCWrite=1, PCSource=2. instr_done=1. Go to FETCH.
- Latency with mem_ready tied to 1 (IDLE excluded):
  - lw: 5 cycles
  - sw: 4 cycles
  - R-format and addi: 4 cycles
  - beq and j: 3 cycles
- Stall counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on any state change.
  - Saturates at MEM_TIMEOUT: on reaching it, mem_err sets; the state keeps holding and waiting.
- Simultaneous events: rst_n=0 overrides mem_ready and every transition.
- Output values are registered-state functions only, so no combinational path runs from opcode to any output except through next-state logic.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2, OP_ADDI=8)
  - ALUOp encodings
  - ALUSrcB and PCSource encodings
  - 4-bit state enum
- The package is shared with the single-cycle control unit.
- One sub-module, mem_stall_timer: the stall counter plus the sticky mem_err flag.

Test Plan:
- Reset then mem_ready=1, opcode=0 -> IDLE (all outputs 0), then FETCH, DECODE, R_EXEC, R_WB. RegWrite=1, RegDst=1 in R_WB; instr_done pulses on cycle 5 after reset release.
- opcode=35, mem_ready low for 3 cycles in MEM_RD -> MemRead=1 and IorD=1 held 4 cycles; LW_WB has MemtoReg=1, RegWrite=1; no RegWrite before that.
- opcode=4 with zero=1, then zero=0 -> BRANCH asserts PCWriteCond=1, PCSource=1, ALUOp=3 in both cases; PCWrite=0.
- opcode=63 -> illegal_op pulse in DECODE, then FETCH next cycle; no RegWrite, MemWrite or PCWrite asserted apart from FETCH.
- mem_ready held 0 in FETCH for 16 cycles -> mem_err=1 after 15 cycles; IRWrite stays 0; mem_ready=1 then proceeds to DECODE with mem_err still 1.
- rst_n=0 during MEM_WR with mem_ready=1 in the same cycle -> next state IDLE, MemWrite=0, instr_done=0, mem_err=0.
